// File: rtl/timebase_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timebase_pkg
//  Description : Shared types and helpers for the clock-display timebase.
//  Revision    : 1.0 - initial release
// ============================================================================
package timebase_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        STABLE   = 2'd1,
        CHANGING = 2'd2
    } db_state_t;

    // Bits needed to hold values 0..modulus-1; never returns zero.
    function automatic int cnt_width(input int modulus);
        return (modulus <= 1) ? 1 : $clog2(modulus);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timebase_gen_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Enabled modulo-N up counter with a roll-over flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import timebase_pkg::*;
#(
    parameter int MODULUS = 4,
    parameter int WIDTH   = cnt_width(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_last) ? '0 : r_count + c_one;
        end
    end

    // High on exactly the enabled edge that returns the count to zero.
    assign o_wrap  = i_en && (r_count == c_last);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/timebase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : timebase_gen
//  Description : 1 ms / 1 s clocks and ticks, debounced 12/24-hour switch and
//                a core reset that releases only after the switch has settled.
//  Revision    : 1.0 - initial release
// ============================================================================
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int CLKS_PER_MS = 50000,
    parameter int MS_PER_SEC  = 1000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic mil_time_raw,
    output logic clk_1ms,
    output logic clk_1sec,
    output logic tick_1ms,
    output logic tick_1sec,
    output logic mil_time,
    output logic reset_n
);

    localparam int c_ms_w  = cnt_width(CLKS_PER_MS);
    localparam int c_sec_w = cnt_width(MS_PER_SEC);
    localparam int c_db_w  = cnt_width(DEBOUNCE_MS + 1);

    localparam logic [c_ms_w-1:0]  c_ms_pre_half  = c_ms_w'(CLKS_PER_MS / 2 - 1);
    localparam logic [c_ms_w-1:0]  c_ms_pre_last  = c_ms_w'(CLKS_PER_MS - 2);
    localparam logic [c_sec_w-1:0] c_sec_pre_half = c_sec_w'(MS_PER_SEC / 2 - 1);
    localparam logic [c_sec_w-1:0] c_sec_last     = c_sec_w'(MS_PER_SEC - 1);
    localparam logic [c_db_w-1:0]  c_db_last      = c_db_w'(DEBOUNCE_MS - 1);
    localparam logic [c_db_w-1:0]  c_db_one       = c_db_w'(1);

    logic [c_ms_w-1:0]  w_ms_cnt;
    logic [c_sec_w-1:0] w_sec_cnt;
    logic               w_ms_wrap;
    logic               w_sec_wrap;

    logic r_clk_1ms;
    logic r_tick_1ms;
    logic r_clk_1sec;
    logic r_tick_1sec;

    logic r_sync_meta;
    logic r_sync;

    db_state_t          r_state;
    db_state_t          w_state_nxt;
    logic [c_db_w-1:0]  r_db_cnt;
    logic [c_db_w-1:0]  w_db_cnt_nxt;
    logic               r_mil_time;
    logic               w_mil_time_nxt;
    logic               r_reset_n;
    logic               w_reset_n_nxt;
    logic               w_db_done;

    mod_counter #(
        .MODULUS (CLKS_PER_MS)
    ) u_ms_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (1'b1),
        .o_count (w_ms_cnt),
        .o_wrap  (w_ms_wrap)
    );

    mod_counter #(
        .MODULUS (MS_PER_SEC)
    ) u_sec_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (r_tick_1ms),
        .o_count (w_sec_cnt),
        .o_wrap  (w_sec_wrap)
    );

    // Output flops decode the count one step early so they line up with
    // the counter value they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_1ms   <= 1'b0;
            r_tick_1ms  <= 1'b0;
            r_clk_1sec  <= 1'b0;
            r_tick_1sec <= 1'b0;
        end else begin
            if (w_ms_wrap) begin
                r_clk_1ms <= 1'b0;
            end else if (w_ms_cnt == c_ms_pre_half) begin
                r_clk_1ms <= 1'b1;
            end

            if (w_sec_wrap) begin
                r_clk_1sec <= 1'b0;
            end else if (r_tick_1ms && (w_sec_cnt == c_sec_pre_half)) begin
                r_clk_1sec <= 1'b1;
            end

            r_tick_1ms  <= (w_ms_cnt == c_ms_pre_last);
            r_tick_1sec <= (w_ms_cnt == c_ms_pre_last) && (w_sec_cnt == c_sec_last);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= mil_time_raw;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_db_done = r_tick_1ms && (r_db_cnt == c_db_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= INIT;
            r_db_cnt   <= '0;
            r_mil_time <= 1'b0;
            r_reset_n  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_cnt_nxt;
            r_mil_time <= w_mil_time_nxt;
            r_reset_n  <= w_reset_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT: begin
                if (w_db_done) begin
                    w_state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (r_sync != r_mil_time) begin
                    w_state_nxt = CHANGING;
                end
            end
            CHANGING: begin
                // A switch that has returned wins over a coincident final tick.
                if ((r_sync == r_mil_time) || w_db_done) begin
                    w_state_nxt = STABLE;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    always_comb begin
        w_db_cnt_nxt   = r_db_cnt;
        w_mil_time_nxt = r_mil_time;
        w_reset_n_nxt  = r_reset_n;
        case (r_state)
            INIT: begin
                w_mil_time_nxt = r_sync;
                if (w_db_done) begin
                    w_db_cnt_nxt  = '0;
                    w_reset_n_nxt = 1'b1;
                end else if (r_tick_1ms) begin
                    w_db_cnt_nxt = r_db_cnt + c_db_one;
                end
            end
            STABLE: begin
                if (r_sync != r_mil_time) begin
                    w_db_cnt_nxt = '0;
                end
            end
            CHANGING: begin
                if (r_sync == r_mil_time) begin
                    w_db_cnt_nxt = '0;
                end else if (w_db_done) begin
                    w_db_cnt_nxt   = '0;
                    w_mil_time_nxt = r_sync;
                end else if (r_tick_1ms) begin
                    w_db_cnt_nxt = r_db_cnt + c_db_one;
                end
            end
            default: w_db_cnt_nxt = '0;
        endcase
    end

    assign clk_1ms   = r_clk_1ms;
    assign tick_1ms  = r_tick_1ms;
    assign clk_1sec  = r_clk_1sec;
    assign tick_1sec = r_tick_1sec;
    assign mil_time  = r_mil_time;
    assign reset_n   = r_reset_n;

endmodule
`default_nettype wire

// File: tb/tb_timebase_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_timebase_gen
//  Description : Self-checking bench for timebase_gen against an edge-count
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timebase_gen;

    localparam int C = 4;
    localparam int S = 10;
    localparam int D = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mil_time_raw = 1'b1;
    logic clk_1ms, clk_1sec, tick_1ms, tick_1sec, mil_time, reset_n;

    timebase_gen #(
        .CLKS_PER_MS (C),
        .MS_PER_SEC  (S),
        .DEBOUNCE_MS (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mil_time_raw (mil_time_raw),
        .clk_1ms      (clk_1ms),
        .clk_1sec     (clk_1sec),
        .tick_1ms     (tick_1ms),
        .tick_1sec    (tick_1sec),
        .mil_time     (mil_time),
        .reset_n      (reset_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_k = edges since reset release; the debounce is
    // described by when a disagreement started and how many ms boundaries
    // have passed since then.
    int   m_k;
    logic m_s1, m_s2, m_mil;
    bit   m_watch;
    int   m_start;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, m_k, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_s1 = 1'b0; m_s2 = 1'b0; m_mil = 1'b0; m_watch = 1'b0; m_start = 0;
    endtask

    task automatic model_edge();
        int  k_new;
        bit  tick_seen;
        k_new     = m_k + 1;
        tick_seen = (k_new % C) == 0;
        if (k_new <= C * D) begin
            m_mil = m_s2;
        end else if (!m_watch) begin
            if (m_s2 != m_mil) begin
                m_watch = 1'b1;
                m_start = k_new;
            end
        end else if (m_s2 == m_mil) begin
            m_watch = 1'b0;
        end else if (tick_seen && (k_new / C - m_start / C) == D) begin
            m_mil   = m_s2;
            m_watch = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = mil_time_raw;
        m_k  = k_new;
    endtask

    task automatic compare_all();
        int ms, sc, exp_state, exp_db;
        ms = m_k % C;
        sc = (m_k / C) % S;
        if (m_k < C * D) begin
            exp_state = 0; exp_db = m_k / C;
        end else if (m_watch) begin
            exp_state = 2; exp_db = m_k / C - m_start / C;
        end else begin
            exp_state = 1; exp_db = 0;
        end
        check_eq("clk_1ms",   32'(clk_1ms),   32'(ms >= C / 2));
        check_eq("tick_1ms",  32'(tick_1ms),  32'(ms == C - 1));
        check_eq("clk_1sec",  32'(clk_1sec),  32'(sc >= S / 2));
        check_eq("tick_1sec", 32'(tick_1sec), 32'(ms == C - 1 && sc == S - 1));
        check_eq("reset_n",   32'(reset_n),   32'(m_k >= C * D));
        check_eq("mil_time",  32'(mil_time),  32'(m_mil));
        check_eq("db_state",  32'(dut.r_state),  32'(exp_state));
        check_eq("db_cnt",    32'(dut.r_db_cnt), 32'(exp_db));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_clk_1ms"},   32'(clk_1ms),   32'(0));
        check_eq({tag, "_clk_1sec"},  32'(clk_1sec),  32'(0));
        check_eq({tag, "_tick_1ms"},  32'(tick_1ms),  32'(0));
        check_eq({tag, "_tick_1sec"}, 32'(tick_1sec), 32'(0));
        check_eq({tag, "_mil_time"},  32'(mil_time),  32'(0));
        check_eq({tag, "_reset_n"},   32'(reset_n),   32'(0));
    endtask

    initial begin
        int n_1s, first_1s, lone_1s, hi_1s, waited, k0, hold, rise;
        bit fell, seen_chg;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Power-up window and two full seconds.
        n_1s = 0; first_1s = -1; lone_1s = 0; hi_1s = 0;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (tick_1sec) begin
                n_1s++;
                if (first_1s < 0) first_1s = i;
                if (!tick_1ms) lone_1s++;
            end
            if (i <= 80 && clk_1sec) hi_1s++;
            if (i == 11) check_eq("s1_reset_n_edge11", 32'(reset_n), 32'(0));
            if (i == 12) begin
                check_eq("s1_reset_n_edge12", 32'(reset_n), 32'(1));
                check_eq("s1_mil_edge12", 32'(mil_time), 32'(1));
            end
        end
        check_eq("s2_tick_1sec_count", 32'(n_1s), 32'(2));
        check_eq("s2_first_tick_1sec", 32'(first_1s), 32'(39));
        check_eq("s2_tick_1sec_alone", 32'(lone_1s), 32'(0));
        check_eq("s2_clk_1sec_high", 32'(hi_1s), 32'(40));

        // Permanent change: raw set after edge 100 -> falls on edge 112.
        mil_time_raw = 1'b0;
        fell = 1'b0; waited = 0;
        for (int i = 1; i <= 40 && !fell; i++) begin
            cycle();
            waited = i;
            if (mil_time == 1'b0) fell = 1'b1;
        end
        check_eq("s3_mil_fell", 32'(fell), 32'(1));
        check_eq("s3_fall_latency", 32'(waited), 32'(12));
        cycle();
        check_eq("s3_state_stable", 32'(dut.r_state), 32'(1));

        // Restore 1 and let it settle.
        mil_time_raw = 1'b1;
        repeat (20) cycle();
        check_eq("s4_pre_mil", 32'(mil_time), 32'(1));

        // Short glitch of 6 clocks.
        mil_time_raw = 1'b0;
        seen_chg = 1'b0;
        repeat (6) begin
            cycle();
            if (dut.r_state == 2'd2) seen_chg = 1'b1;
        end
        mil_time_raw = 1'b1;
        repeat (12) begin
            cycle();
            if (dut.r_state == 2'd2) seen_chg = 1'b1;
        end
        check_eq("s4_seen_changing", 32'(seen_chg), 32'(1));
        check_eq("s4_mil_kept", 32'(mil_time), 32'(1));
        check_eq("s4_state_stable", 32'(dut.r_state), 32'(1));
        check_eq("s4_db_cnt_zero", 32'(dut.r_db_cnt), 32'(0));

        // Glitch whose return lands on a sampled ms tick.
        for (int i = 0; i < 8 && (m_k % C) != 1; i++) cycle();
        k0 = m_k;
        mil_time_raw = 1'b0;
        repeat (4) cycle();
        mil_time_raw = 1'b1;
        seen_chg = 1'b0;
        repeat (2) begin
            cycle();
            if (dut.r_state == 2'd2) seen_chg = 1'b1;
        end
        check_eq("s5_changing_before", 32'(seen_chg), 32'(1));
        check_eq("s5_tick_pending", 32'(tick_1ms), 32'(1));
        cycle();
        check_eq("s5_edge_offset", 32'(m_k - k0), 32'(7));
        check_eq("s5_state_stable", 32'(dut.r_state), 32'(1));
        check_eq("s5_db_cnt_zero", 32'(dut.r_db_cnt), 32'(0));
        check_eq("s5_mil_kept", 32'(mil_time), 32'(1));

        // Reset in the middle of a second with the switch at 0.
        mil_time_raw = 1'b0;
        for (int i = 0; i < 60 && ((m_k / C) % S) != 6; i++) cycle();
        check_eq("s6_clk_1sec_before", 32'(clk_1sec), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("s6_async");
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        rise = -1;
        for (int i = 1; i <= 30 && rise < 0; i++) begin
            cycle();
            if (reset_n) rise = i;
        end
        check_eq("s6_reset_n_rise_edge", 32'(rise), 32'(12));
        check_eq("s6_mil_after", 32'(mil_time), 32'(0));

        // Randomized switch activity with occasional resets.
        for (int it = 0; it < 60; it++) begin
            mil_time_raw = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 16);
            repeat (hold) cycle();
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                #1;
                check_reset_outputs("rnd_async");
                model_reset();
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                compare_all();
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
